// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/mem/writeback sequencer with halt latch
// and retired-instruction counter.
module cpu_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch,
    input  logic             loadStore,
    input  logic             dataRegister,
    input  logic             dataRegisterImm,
    input  logic             setFlags,
    input  logic             halt,
    input  logic             is_store,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic             flags_write,
    output logic             wb_sel_mem,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
    state_t cur;
    logic active, isBr, isLs, isData, isSf, isStore;
    // active holds the first fetch request off until the first edge after reset release
    always_comb begin
        state       = cur;
        imem_req    = active && cur == FETCH;
        ir_load     = imem_req && imem_ack;
        dmem_req    = cur == MEM;
        dmem_we     = dmem_req && isStore;
        reg_write   = cur == WB;
        wb_sel_mem  = reg_write && isLs;
        flags_write = reg_write && !isLs && isData && isSf;
        pc_load     = cur == EXECUTE && isBr && branch_taken;
        pc_inc      = (cur == EXECUTE && (isBr ? !branch_taken : !isLs && !isData))
                      || (dmem_req && dmem_ack && isStore) || reg_write;
        halted      = cur == HALT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= FETCH;
            active  <= 1'b0;
            isBr    <= 1'b0;
            isLs    <= 1'b0;
            isData  <= 1'b0;
            isSf    <= 1'b0;
            isStore <= 1'b0;
            retired <= '0;
        end else begin
            active <= 1'b1;
            if (pc_inc || pc_load)
                retired <= retired + CNT_W'(1);
            case (cur)
                FETCH:   if (ir_load) cur <= DECODE;
                DECODE: begin
                    isBr    <= branch;
                    isLs    <= loadStore;
                    isData  <= dataRegister || dataRegisterImm;
                    isSf    <= setFlags;
                    isStore <= loadStore && is_store;
                    cur     <= halt ? HALT : EXECUTE;
                end
                EXECUTE: cur <= isBr ? FETCH : isLs ? MEM : isData ? WB : FETCH;
                MEM:     if (dmem_ack) cur <= isStore ? FETCH : WB;
                WB:      cur <= FETCH;
                HALT:    cur <= HALT;
                default: cur <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: per-cycle vector table for the instruction classes plus directed
// halt, asynchronous reset and counter wrap sequences.
module tb_cpu_seq_ctrl;
    localparam logic [9:0] IREQ = 10'b1000000000, IRL = 10'b0100000000, DREQ = 10'b0010000000,
                           DWE = 10'b0001000000, RW = 10'b0000100000, FW = 10'b0000010000,
                           WSM = 10'b0000001000, PCI = 10'b0000000100, PCL = 10'b0000000010,
                           HLT = 10'b0000000001;
    // decoder field order: {branch, loadStore, dataRegister, dataRegisterImm, setFlags, halt}
    localparam logic [5:0] D_BR = 6'b100000, D_LS = 6'b010000, D_DR = 6'b001000,
                           D_DRI = 6'b000100, D_SF = 6'b000010, D_HLT = 6'b000001;

    logic clk = 1'b0, rst = 1'b0;
    logic branch, loadStore, dataRegister, dataRegisterImm, setFlags, halt;
    logic is_store, branch_taken, imem_ack, dmem_ack;
    logic imem_req, ir_load, dmem_req, dmem_we, reg_write, flags_write, wb_sel_mem;
    logic pc_inc, pc_load, halted;
    logic [2:0] state;
    logic [3:0] retired;
    logic [9:0] outs;
    int total = 0, bad = 0;

    assign outs = {imem_req, ir_load, dmem_req, dmem_we, reg_write, flags_write, wb_sel_mem,
                   pc_inc, pc_load, halted};

    cpu_seq_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .branch(branch), .loadStore(loadStore),
        .dataRegister(dataRegister), .dataRegisterImm(dataRegisterImm), .setFlags(setFlags),
        .halt(halt), .is_store(is_store), .branch_taken(branch_taken), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_write(reg_write), .flags_write(flags_write),
        .wb_sel_mem(wb_sel_mem), .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] dec;
        logic       st, bt, ia, da;
        logic [2:0] es;
        logic [9:0] eo;
        logic [3:0] er;
    } vec_t;
    vec_t vt[30];

    task automatic drive(input logic [5:0] d, input logic s, input logic b, input logic ia,
                         input logic da);
        {branch, loadStore, dataRegister, dataRegisterImm, setFlags, halt} = d;
        is_store = s;
        branch_taken = b;
        imem_ack = ia;
        dmem_ack = da;
    endtask

    task automatic check(input string nm, input logic [2:0] es, input logic [9:0] eo,
                         input logic [3:0] er);
        total++;
        if ({state, outs, retired} !== {es, eo, er}) begin
            bad++;
            $display("FAIL %s: got state=%0d outs=%b retired=%0d, want state=%0d outs=%b retired=%0d",
                     nm, state, outs, retired, es, eo, er);
        end
    endtask

    task automatic cycle(input string nm, input logic [5:0] d, input logic s, input logic b,
                         input logic ia, input logic da, input logic [2:0] es,
                         input logic [9:0] eo, input logic [3:0] er);
        @(negedge clk);
        drive(d, s, b, ia, da);
        #1 check(nm, es, eo, er);
    endtask

    initial begin
        // ADD-class, setFlags; stray acks in DECODE, decoder noise in EXECUTE
        vt[0]  = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 0};
        vt[1]  = '{D_DR | D_SF, 0, 0, 1, 1, 1, 10'd0, 0};
        vt[2]  = '{D_BR | D_LS | D_HLT, 1, 1, 1, 1, 2, 10'd0, 0};
        vt[3]  = '{6'h00, 0, 0, 0, 0, 4, RW | FW | PCI, 0};
        // load with setFlags set (must not write flags), dmem_ack two cycles late
        vt[4]  = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 1};
        vt[5]  = '{D_LS | D_SF, 0, 0, 0, 0, 1, 10'd0, 1};
        vt[6]  = '{6'h00, 0, 0, 0, 0, 2, 10'd0, 1};
        vt[7]  = '{6'h00, 0, 0, 0, 0, 3, DREQ, 1};
        vt[8]  = '{6'h00, 0, 0, 0, 0, 3, DREQ, 1};
        vt[9]  = '{6'h00, 0, 0, 0, 1, 3, DREQ, 1};
        vt[10] = '{6'h00, 0, 0, 0, 0, 4, RW | WSM | PCI, 1};
        // store with one-cycle fetch delay
        vt[11] = '{6'h00, 0, 0, 0, 0, 0, IREQ, 2};
        vt[12] = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 2};
        vt[13] = '{D_LS, 1, 0, 0, 0, 1, 10'd0, 2};
        vt[14] = '{6'h00, 0, 0, 0, 0, 2, 10'd0, 2};
        vt[15] = '{6'h00, 0, 0, 0, 1, 3, DREQ | DWE | PCI, 2};
        // taken branch, untaken branch
        vt[16] = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 3};
        vt[17] = '{D_BR, 0, 0, 0, 0, 1, 10'd0, 3};
        vt[18] = '{6'h00, 0, 1, 0, 0, 2, PCL, 3};
        vt[19] = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 4};
        vt[20] = '{D_BR, 0, 1, 0, 0, 1, 10'd0, 4};
        vt[21] = '{6'h00, 0, 0, 0, 0, 2, PCI, 4};
        // NOP (no class bit)
        vt[22] = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 5};
        vt[23] = '{6'h00, 0, 0, 0, 0, 1, 10'd0, 5};
        vt[24] = '{6'h00, 0, 0, 0, 0, 2, PCI, 5};
        // immediate data op without setFlags
        vt[25] = '{6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 6};
        vt[26] = '{D_DRI, 0, 0, 0, 0, 1, 10'd0, 6};
        vt[27] = '{6'h00, 0, 0, 0, 0, 2, 10'd0, 6};
        vt[28] = '{6'h00, 0, 0, 0, 0, 4, RW | PCI, 6};
        vt[29] = '{6'h00, 0, 0, 0, 0, 0, IREQ, 7};

        drive(6'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("reset_hold", 0, 10'd0, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_release", 0, 10'd0, 0);

        for (int i = 0; i < 30; i++)
            cycle($sformatf("vec%0d", i), vt[i].dec, vt[i].st, vt[i].bt, vt[i].ia, vt[i].da,
                  vt[i].es, vt[i].eo, vt[i].er);

        // halt: stays halted with stray acks and noisy decoder inputs
        cycle("halt_fetch", 6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 7);
        cycle("halt_decode", D_DR | D_HLT, 0, 0, 1, 1, 1, 10'd0, 7);
        for (int i = 0; i < 22; i++)
            cycle("halt_hold", 6'h3f, 1, 1, 1, 1, 5, HLT, 7);
        @(negedge clk);
        rst = 1'b0;
        #1 check("halt_rst", 0, 10'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(6'h00, 0, 0, 0, 0);
        #1 check("halt_rst_release", 0, 10'd0, 0);
        cycle("halt_restart", 6'h00, 0, 0, 0, 0, 0, IREQ, 0);

        // one instruction retired, then reset mid-MEM of a load
        cycle("pre_f", 6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 0);
        cycle("pre_d", 6'h00, 0, 0, 0, 0, 1, 10'd0, 0);
        cycle("pre_e", 6'h00, 0, 0, 0, 0, 2, PCI, 0);
        cycle("mem_f", 6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 1);
        cycle("mem_d", D_LS, 0, 0, 0, 0, 1, 10'd0, 1);
        cycle("mem_e", 6'h00, 0, 0, 0, 0, 2, 10'd0, 1);
        cycle("mem_wait", 6'h00, 0, 0, 0, 0, 3, DREQ, 1);
        #2 rst = 1'b0;
        #1 check("mem_rst_async", 0, 10'd0, 0);
        @(negedge clk);
        #1 check("mem_rst_hold", 0, 10'd0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1 check("mem_rst_restart", 0, IREQ, 0);

        // 16 NOPs: 4-bit counter passes 15 and wraps to 0
        for (int i = 0; i < 16; i++) begin
            cycle("wrap_f", 6'h00, 0, 0, 1, 0, 0, IREQ | IRL, 4'(i));
            cycle("wrap_d", 6'h00, 0, 0, 0, 0, 1, 10'd0, 4'(i));
            cycle("wrap_e", 6'h00, 0, 0, 0, 0, 2, PCI, 4'(i));
        end
        cycle("wrap_zero", 6'h00, 0, 0, 0, 0, 0, IREQ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
